mm_booth_mac: RTL

//  Iterative radix-4 Booth multiplier with per-operation signed/unsigned mode and optional accumulate.

---
 rtl/mm_booth_mac_if.sv | 28 ++
 rtl/mm_booth_mac.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mm_booth_mac_if.sv
// Operand and result handshake bundle for the radix-4 Booth MAC.
// The master drives operands and out_ready; the slave returns results.
interface mm_booth_mac_if #(
  parameter int INWIDTH  = 16,
  parameter int ACCWIDTH = 2*INWIDTH+8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INWIDTH-1:0]    a;
  logic [INWIDTH-1:0]    b;
  logic                  op_signed;
  logic                  op_acc;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*INWIDTH-1:0]  product;
  logic [ACCWIDTH-1:0]   acc;
  logic                  acc_ovf;

  modport master (
    output in_valid, a, b, op_signed, op_acc, out_ready,
    input  in_ready, out_valid, product, acc, acc_ovf
  );

  modport slave (
    input  in_valid, a, b, op_signed, op_acc, out_ready,
    output in_ready, out_valid, product, acc, acc_ovf
  );
endinterface

// File: rtl/mm_booth_mac.sv
// Iterative radix-4 Booth multiply-accumulate element.
// Signed/unsigned per operation, optional accumulate, sticky overflow.
module mm_booth_mac #(
  parameter int INWIDTH  = 16,
  parameter int ACCWIDTH = 2*INWIDTH+8
) (
  input logic           clk,
  input logic           rst_n,
  mm_booth_mac_if.slave bus
);
  localparam int OUTWIDTH = 2*INWIDTH;
  localparam int EXTW     = INWIDTH+2;
  localparam int ITER     = EXTW/2;
  localparam int PW       = 2*EXTW+1;
  localparam int CW       = $clog2(ITER+1);

  generate
    if ((INWIDTH % 2) != 0 || INWIDTH < 4) begin : g_bad_in
      $error("mm_booth_mac: INWIDTH must be even and >= 4");
    end
    if (ACCWIDTH < 2*INWIDTH) begin : g_bad_acc
      $error("mm_booth_mac: ACCWIDTH must be >= 2*INWIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [EXTW-1:0]      mcand_q;
  logic [PW-1:0]        p_q;
  logic                 lost_q;
  logic [CW-1:0]        cnt_q;
  logic                 sgn_q;
  logic                 accm_q;
  logic [OUTWIDTH-1:0]  product_q;
  logic [ACCWIDTH-1:0]  acc_q;
  logic                 ovf_q;

  logic [EXTW-1:0]      a_ext;
  logic [EXTW-1:0]      b_ext;
  logic [EXTW:0]        a1;
  logic [EXTW:0]        a2;
  logic [EXTW:0]        addend;
  logic [EXTW:0]        hi_sum;
  logic [PW-1:0]        p_sh;
  logic [OUTWIDTH-1:0]  res;
  logic                 last;
  logic [ACCWIDTH-1:0]  base;
  logic [ACCWIDTH-1:0]  ext;
  logic [ACCWIDTH:0]    sum;
  logic                 ovf_now;

  assign a_ext = bus.op_signed ?
    {{2{bus.a[INWIDTH-1]}}, bus.a} : {2'b00, bus.a};
  assign b_ext = bus.op_signed ?
    {{2{bus.b[INWIDTH-1]}}, bus.b} : {2'b00, bus.b};

  assign a1 = {mcand_q[EXTW-1], mcand_q};
  assign a2 = {mcand_q, 1'b0};

  always_comb begin
    addend = '0;
    case ({p_q[1:0], lost_q})
      3'b001, 3'b010: addend = a1;
      3'b011:         addend = a2;
      3'b100:         addend = -a2;
      3'b101, 3'b110: addend = -a1;
      default:        addend = '0;
    endcase
  end

  // Add into the upper half, then arithmetic shift right by two.
  assign hi_sum = p_q[PW-1 -: EXTW+1] + addend;
  assign p_sh   = {{2{hi_sum[EXTW]}}, hi_sum, p_q[EXTW-1:2]};
  assign res    = p_sh[OUTWIDTH-1:0];
  assign last   = (cnt_q == CW'(1));

  assign base = accm_q ? acc_q : '0;
  assign ext  = sgn_q ? ACCWIDTH'($signed(res)) : ACCWIDTH'(res);
  assign sum  = {1'b0, base} + {1'b0, ext};

  assign ovf_now = sgn_q ?
    ((base[ACCWIDTH-1] == ext[ACCWIDTH-1]) &&
     (sum[ACCWIDTH-1] != base[ACCWIDTH-1])) :
    sum[ACCWIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      p_q       <= '0;
      lost_q    <= 1'b0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      accm_q    <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_q <= a_ext;
            p_q     <= {{(EXTW+1){1'b0}}, b_ext};
            lost_q  <= 1'b0;
            cnt_q   <= CW'(ITER);
            sgn_q   <= bus.op_signed;
            accm_q  <= bus.op_acc;
          end
        end
        CALC: begin
          p_q    <= p_sh;
          lost_q <= p_q[1];
          cnt_q  <= cnt_q - CW'(1);
          if (last) begin
            product_q <= res;
            acc_q     <= sum[ACCWIDTH-1:0];
            ovf_q     <= accm_q ? (ovf_q | ovf_now) : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = product_q;
  assign bus.acc       = acc_q;
  assign bus.acc_ovf   = ovf_q;
endmodule
